mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter for a single synchronous data-memory port.
// Optional macro ARB_ROUND_ROBIN_EN: bounded CPU bursts and alternating priority.
module mem_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 24,
  parameter int DMA_MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CPU  = 2'd1;
  localparam logic [1:0] DMA  = 2'd2;

  localparam logic [7:0] LAST_BEAT = 8'(DMA_MAX_BURST - 1);

  logic [1:0] state, state_nx;
  logic [7:0] cnt;
  logic       cpu_xfer, dma_xfer, count_en, at_limit;
  logic       cpu_rd_q, dma_rd_q;

  assign cpu_gnt  = (state == CPU);
  assign dma_gnt  = (state == DMA);
  assign cpu_xfer = cpu_gnt & cpu_req;
  assign dma_xfer = dma_gnt & dma_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_cpu;
  assign count_en = cpu_xfer | dma_xfer;
`else
  assign count_en = dma_xfer;
`endif
  assign at_limit = count_en && (cnt == LAST_BEAT);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (cpu_req && dma_req) state_nx = last_cpu ? DMA : CPU;
        else
`endif
        if (cpu_req)      state_nx = CPU;
        else if (dma_req) state_nx = DMA;
      end
      CPU: begin
        if (!cpu_req) state_nx = dma_req ? DMA : IDLE;
`ifdef ARB_ROUND_ROBIN_EN
        else if (at_limit && dma_req) state_nx = DMA;
`endif
      end
      DMA: begin
        if (!dma_req || at_limit)
          state_nx = cpu_req ? CPU : (dma_req ? DMA : IDLE);
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cpu_rd_q <= 1'b0;
      dma_rd_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cpu_rd_q <= cpu_xfer & ~cpu_we;
      dma_rd_q <= dma_xfer & ~dma_we;
      // A new grant or a completed burst restarts the count; it never wraps.
      if (state_nx != state || at_limit) cnt <= '0;
      else if (count_en)                 cnt <= cnt + 8'd1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset value makes DMA the first winner of a simultaneous request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            last_cpu <= 1'b1;
    else if (cpu_gnt)   last_cpu <= 1'b1;
    else if (dma_gnt)   last_cpu <= 1'b0;
  end
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      CPU: begin
        mem_we    = cpu_req & cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      DMA: begin
        mem_we    = dma_req & dma_we;
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  // Read-valid flags carry the requester captured at transfer time.
  assign cpu_rvalid = cpu_rd_q;
  assign dma_rvalid = dma_rd_q;
  assign cpu_rdata  = cpu_rd_q ? mem_q : '0;
  assign dma_rdata  = dma_rd_q ? mem_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default fixed-priority build).
module tb_mem_arbiter;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 24;

  logic              clk, rst;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_q;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_we;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMA_MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model behind the arbiter.
  logic [DATA_W-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_q <= ram[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive_point();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int dma_n, first_cpu, overlap, gaps;
    for (int a = 0; a < 256; a++) ram[a] = '0;
    rst = 1'b1; cpu_req = 1'b1; dma_req = 1'b1; cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = 19'd9; dma_addr = 19'd11; cpu_wdata = 24'h123; dma_wdata = 24'h456;

    // Reset with both requests high: everything quiet
    drive_point(); drive_point(); settle();
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_dma_gnt", 32'(dma_gnt), 32'd0);
    check("rst_mem_we",  32'(mem_we),  32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
    check("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);

    drive_point(); rst = 1'b0; settle();
    check("release_still_idle", 32'(cpu_gnt), 32'd0);
    drive_point();
    dma_req = 1'b0; cpu_we = 1'b1; cpu_addr = 19'd75; cpu_wdata = 24'd255;
    settle();
    check("cpu_first_gnt", 32'(cpu_gnt), 32'd1);
    check("cpu_first_dma_gnt", 32'(dma_gnt), 32'd0);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_mem_addr", 32'(mem_addr), 32'd75);
    check("wr_mem_wdata", 32'(mem_wdata), 32'd255);

    drive_point(); cpu_we = 1'b0; settle();
    check("rd_mem_we", 32'(mem_we), 32'd0);
    check("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
    drive_point(); cpu_req = 1'b0; settle();
    check("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rd_cpu_rdata", 32'(cpu_rdata), 32'd255);
    check("rd_dma_rvalid", 32'(dma_rvalid), 32'd0);
    drive_point(); settle();
    check("rvalid_one_cycle", 32'(cpu_rvalid), 32'd0);
    check("rdata_zero", 32'(cpu_rdata), 32'd0);
    check("idle_no_gnt", 32'(cpu_gnt), 32'd0);
    check("idle_mem_addr", 32'(mem_addr), 32'd0);

    // Request while not granted: no memory access
    drive_point(); cpu_req = 1'b1; cpu_we = 1'b1; settle();
    check("ungranted_mem_we", 32'(mem_we), 32'd0);
    drive_point(); cpu_req = 1'b0; cpu_we = 1'b0;
    drive_point(); settle();
    check("back_to_idle", 32'(dut.state), 32'd0);

    // DMA burst capped at 8, CPU raised at cycle 3
    dma_n = 0; first_cpu = -1; overlap = 0;
    dma_addr = 19'd75; dma_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_point(); dma_req = 1'b1; cpu_req = (i >= 3); settle();
      if (dma_gnt && first_cpu < 0) dma_n++;
      if (cpu_gnt && first_cpu < 0) first_cpu = i;
      if (cpu_gnt && dma_gnt) overlap++;
      if (i == 9) begin
        check("handoff_dma_rvalid", 32'(dma_rvalid), 32'd1);
        check("handoff_dma_rdata", 32'(dma_rdata), 32'd255);
        check("handoff_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      end
    end
    check("burst_dma_xfers", 32'(dma_n), 32'd8);
    check("burst_first_cpu", 32'(first_cpu), 32'd9);
    check("burst_no_overlap", 32'(overlap), 32'd0);
    drive_point(); cpu_req = 1'b0; dma_req = 1'b0;
    drive_point(); settle();
    check("burst_end_idle", 32'(dut.state), 32'd0);

    // DMA alone: continuous grant, counter restarts each 8 transfers
    gaps = 0;
    for (int i = 0; i < 20; i++) begin
      drive_point(); dma_req = 1'b1; settle();
      if (i >= 1) begin
        if (!dma_gnt) gaps++;
        check($sformatf("dma_cnt_%0d", i), 32'(dut.cnt), 32'((i - 1) % 8));
      end
    end
    check("dma_solo_no_gap", 32'(gaps), 32'd0);
    drive_point(); dma_req = 1'b0;
    drive_point(); settle();
    check("dma_solo_idle", 32'(dut.state), 32'd0);

    // Reset right after a DMA read of addr 40 discards the read
    drive_point(); dma_req = 1'b1; dma_we = 1'b0; dma_addr = 19'd40;
    drive_point();
    drive_point(); rst = 1'b1; dma_req = 1'b0; settle();
    check("rst_kill_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_kill_gnt", 32'(dma_gnt), 32'd0);
    drive_point(); rst = 1'b0;
    gaps = 0;
    for (int i = 0; i < 3; i++) begin
      drive_point(); settle();
      if (dma_rvalid) gaps++;
    end
    check("post_rst_no_rvalid", 32'(gaps), 32'd0);
    check("post_rst_idle", 32'(dut.state), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
